kbd_input_ctrl: RTL and testbench
=================================

Name: kbd_input_ctrl

Overview:
- Sits between the PS/2 keyboard receiver and the processor's input (IN) instruction path.
- Buffers decoded ASCII bytes in a small circular FIFO and optionally applies line editing: backspace removes a character; Enter commits the line.
- Stalls the processor until a committed byte exists, delivers it with a one-cycle done pulse, and emits an echo stream for the display.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of two.
- ADDR_W, 4: log2(DEPTH).
- LINE_MODE, 1: 1 = bytes are held until Enter (0x0D); 0 = every byte is committed immediately.
- DATA_W, 32: processor word width; the byte is zero-extended to this width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- kb_data  in  8  ASCII byte from the keyboard receiver.
- kb_valid  in  1  one-cycle strobe; kb_data is valid while high.
- in_req  in  1  level; the processor is executing IN. Held high until in_done is seen.
- in_flush  in  1  one-cycle pulse; discards all buffered bytes.
- in_stall  out  1  combinational; processor must freeze while high.
- in_data  out  DATA_W  delivered byte, zero-extended.
- in_done  out  1  one-cycle pulse; in_data is valid.
- echo_data  out  8  byte to display.
- echo_valid  out  1  one-cycle echo strobe.
- count  out  ADDR_W+1  committed bytes available.
- overflow  out  1  sticky; a byte was dropped.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Pointers wr_ptr, commit_ptr and rd_ptr (each ADDR_W+1 bits, wrap modulo 2*DEPTH) are 0.
  - FSM is in IDLE.
  - FIFO storage is not reset.
- Derived signals:
  - occupancy = wr_ptr - rd_ptr
  - full = (occupancy == DEPTH)
  - avail = (commit_ptr != rd_ptr)
  - count = commit_ptr - rd_ptr
- Write side, on each clk edge where kb_valid=1 and in_flush=0:
  - Backspace (0x08), LINE_MODE=1:
    - If wr_ptr != commit_ptr: wr_ptr--, echo 0x08.
    - Otherwise ignore with no echo.
  - Otherwise, if full: drop the byte, set overflow=1, no echo.
  - Otherwise: mem[wr_ptr[ADDR_W-1:0]] <= kb_data and wr_ptr++. Then:
    - Commit (commit_ptr <= new wr_ptr) if LINE_MODE=0 or kb_data=0x0D.
    - Echo the byte.
  - Backspace with LINE_MODE=0 is stored like any other byte.
- Deadlock guard: if the write leaves full=1 and commit_ptr==rd_ptr (the whole buffer is uncommitted), force commit_ptr <= wr_ptr.
- echo_valid/echo_data are registered and appear one cycle after the kb_valid edge.
- Read FSM (states IDLE, WAIT, HOLD):
  - IDLE:
    - in_req & avail -> HOLD.
    - in_req & ~avail -> WAIT.
  - WAIT: avail -> HOLD.
  - On any transition into HOLD:
    - in_data <= zero-extended mem[rd_ptr].
    - in_done <= 1 for exactly one cycle.
    - rd_ptr++.
  - HOLD: ~in_req -> IDLE. in_done is not re-asserted while in_req stays high.
  - If in_req drops while in WAIT: return to IDLE with no pop.
- in_stall = in_req & (state==IDLE | state==WAIT).
  - Latency with data already committed: in_done is high the cycle after in_req rises; in_stall is high for exactly 1 cycle.
- A byte committed at edge j makes avail true from edge j; the earliest pop is at edge j+1.
- Push and pop at the same edge are both performed; occupancy is unchanged.
- in_flush:
  - Sets all three pointers to 0 and clears overflow.
  - Takes priority over a simultaneous kb_valid, whose byte is dropped with no echo and overflow not set.
  - FSM state is unaffected; WAIT keeps waiting.
  - If flush and a pop coincide, flush wins and no in_done is produced.
- rst asserted mid-operation: immediate return to reset values; a pending in_done is cancelled.

Decomposition:
- Shared package kbd_pkg holds:
  - ASCII constants: KEY_ENTER=8'h0D, KEY_BKSP=8'h08.
  - FSM state encodings: RD_IDLE, RD_WAIT, RD_HOLD.
- One natural sub-module, kbd_line_fifo: storage plus the three pointers, commit and backspace logic, and the full/avail/count flags.
- kbd_input_ctrl wraps kbd_line_fifo with the read FSM and echo register.

Test Plan:
- LINE_MODE=0: send 0x41, then raise in_req. Expect echo 0x41, in_stall high 1 cycle, in_done with in_data=0x00000041, count 1->0.
- LINE_MODE=1: raise in_req first, then send 'H','I',0x08,'O',0x0D. Expect in_stall held until 0x0D, echoes H,I,08,O,0D, then successive reads return 0x48,0x4F,0x0D.
- LINE_MODE=0: send 17 bytes 0x30..0x40 with no reads. Expect 0x40 dropped with no echo, overflow=1, count=16; then 16 reads return 0x30..0x3F in order.
- LINE_MODE=1: send 16 non-Enter bytes. Expect forced commit with count=16; the 17th byte is dropped and overflow=1.
- Send 0x08 with an empty uncommitted line. Expect no echo and pointers unchanged. Then in_flush in the same cycle as kb_valid=0x41: count=0, overflow=0, no echo.
- Assert rst while in WAIT with in_req high. Expect in_stall and in_done low immediately; after release with in_req still high, the FSM re-enters WAIT and stalls.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants and read-FSM encodings for the keyboard input controller.
package kbd_pkg;

  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_BKSP  = 8'h08;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_HOLD = 2'd2
  } rd_state_t;

endpackage

// File: rtl/kbd_line_fifo.sv
// Circular byte FIFO with an uncommitted tail: bytes between commit_ptr and wr_ptr
// are still editable by backspace and invisible to the reader until committed.
module kbd_line_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int LINE_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  input  logic              pop,
  output logic [7:0]        rd_data,
  output logic              accept,
  output logic              avail,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_OCC = (ADDR_W + 1)'(DEPTH);

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr;
  logic [ADDR_W:0] wr_nxt, commit_nxt, rd_nxt;
  logic [ADDR_W:0] occupancy;
  logic            full, is_bksp, do_bksp, do_write, do_drop;

  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == FULL_OCC);
  assign avail     = (commit_ptr != rd_ptr);
  assign count     = commit_ptr - rd_ptr;
  assign rd_data   = mem[rd_ptr[ADDR_W-1:0]];

  assign is_bksp  = (LINE_MODE != 0) && (wr_data == KEY_BKSP);
  assign do_bksp  = wr_valid & ~flush & is_bksp & (wr_ptr != commit_ptr);
  assign do_write = wr_valid & ~flush & ~is_bksp & ~full;
  assign do_drop  = wr_valid & ~flush & ~is_bksp & full;
  assign accept   = do_bksp | do_write;

  // A buffer filled entirely with uncommitted bytes would never drain, so commit it.
  always_comb begin
    wr_nxt     = wr_ptr;
    commit_nxt = commit_ptr;
    rd_nxt     = rd_ptr;
    if (pop) rd_nxt = rd_ptr + 1'b1;
    if (do_bksp) begin
      wr_nxt = wr_ptr - 1'b1;
    end else if (do_write) begin
      wr_nxt = wr_ptr + 1'b1;
      if (LINE_MODE == 0 || wr_data == KEY_ENTER) commit_nxt = wr_nxt;
      if ((wr_nxt - rd_nxt) == FULL_OCC && commit_nxt == rd_nxt) commit_nxt = wr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_nxt;
      commit_ptr <= commit_nxt;
      rd_ptr     <= rd_nxt;
      if (do_drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/kbd_input_ctrl.sv
// Keyboard-to-IN-instruction bridge: line FIFO, read handshake FSM and display echo.
module kbd_input_ctrl
  import kbd_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int LINE_MODE = 1,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        kb_data,
  input  logic              kb_valid,
  input  logic              in_req,
  input  logic              in_flush,
  output logic              in_stall,
  output logic [DATA_W-1:0] in_data,
  output logic              in_done,
  output logic [7:0]        echo_data,
  output logic              echo_valid,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  rd_state_t  state, state_nxt;
  logic       take, pop, accept, avail;
  logic [7:0] rd_data;

  kbd_line_fifo #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .LINE_MODE(LINE_MODE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_valid(kb_valid),
    .wr_data (kb_data),
    .flush   (in_flush),
    .pop     (pop),
    .rd_data (rd_data),
    .accept  (accept),
    .avail   (avail),
    .count   (count),
    .overflow(overflow)
  );

  // A flush in the same cycle as a would-be pop keeps the FSM waiting instead.
  assign take = in_req & avail & ~in_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE: if (take) state_nxt = RD_HOLD;
               else if (in_req) state_nxt = RD_WAIT;
      RD_WAIT: if (!in_req) state_nxt = RD_IDLE;
               else if (take) state_nxt = RD_HOLD;
      RD_HOLD: if (!in_req) state_nxt = RD_IDLE;
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    in_stall = in_req & ~rst & (state == RD_IDLE || state == RD_WAIT);
    pop      = take & (state != RD_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_done    <= 1'b0;
      in_data    <= '0;
      echo_valid <= 1'b0;
      echo_data  <= '0;
    end else begin
      in_done    <= pop;
      echo_valid <= accept;
      if (pop)    in_data   <= DATA_W'(rd_data);
      if (accept) echo_data <= kb_data;
    end
  end

endmodule

// File: tb/tb_kbd_input_ctrl.sv
// Directed bench for kbd_input_ctrl: instance 0 runs LINE_MODE=0, instance 1 LINE_MODE=1.
module tb_kbd_input_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  kb_data    [2];
  logic        kb_valid   [2];
  logic        in_req     [2];
  logic        in_flush   [2];
  logic        in_stall   [2];
  logic [31:0] in_data    [2];
  logic        in_done    [2];
  logic [7:0]  echo_data  [2];
  logic        echo_valid [2];
  logic [4:0]  count      [2];
  logic        overflow   [2];

  logic [7:0]  eq0[$], eq1[$], rq0[$], rq1[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kbd_input_ctrl #(.DEPTH(16), .ADDR_W(4), .LINE_MODE(0), .DATA_W(32)) u_dut0 (
    .clk(clk), .rst(rst), .kb_data(kb_data[0]), .kb_valid(kb_valid[0]),
    .in_req(in_req[0]), .in_flush(in_flush[0]), .in_stall(in_stall[0]),
    .in_data(in_data[0]), .in_done(in_done[0]), .echo_data(echo_data[0]),
    .echo_valid(echo_valid[0]), .count(count[0]), .overflow(overflow[0]));

  kbd_input_ctrl #(.DEPTH(16), .ADDR_W(4), .LINE_MODE(1), .DATA_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .kb_data(kb_data[1]), .kb_valid(kb_valid[1]),
    .in_req(in_req[1]), .in_flush(in_flush[1]), .in_stall(in_stall[1]),
    .in_data(in_data[1]), .in_done(in_done[1]), .echo_data(echo_data[1]),
    .echo_valid(echo_valid[1]), .count(count[1]), .overflow(overflow[1]));

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(string nm, logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: unexpected output %0h at %0t", nm, act, $time);
  endtask

  // Monitor: compare every echo and every delivered word against the scoreboard queues.
  always @(posedge clk) begin
    #1;
    if (echo_valid[0]) begin
      if (eq0.size() == 0) unexpected("echo0", 32'(echo_data[0]));
      else check("echo0", 32'(echo_data[0]), 32'(eq0.pop_front()));
    end
    if (echo_valid[1]) begin
      if (eq1.size() == 0) unexpected("echo1", 32'(echo_data[1]));
      else check("echo1", 32'(echo_data[1]), 32'(eq1.pop_front()));
    end
    if (in_done[0]) begin
      if (rq0.size() == 0) unexpected("read0", in_data[0]);
      else check("read0", in_data[0], {24'h0, rq0.pop_front()});
    end
    if (in_done[1]) begin
      if (rq1.size() == 0) unexpected("read1", in_data[1]);
      else check("read1", in_data[1], {24'h0, rq1.pop_front()});
    end
  end

  task automatic send(int d, logic [7:0] b, bit echo);
    if (echo) begin
      if (d == 0) eq0.push_back(b);
      else        eq1.push_back(b);
    end
    @(negedge clk);
    kb_data[d]  = b;
    kb_valid[d] = 1'b1;
    @(negedge clk);
    kb_valid[d] = 1'b0;
  endtask

  task automatic wait_done(int d);
    bit seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_done[d] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout%0d: in_done never rose", d);
    end
    in_req[d] = 1'b0;
  endtask

  task automatic do_read(int d, logic [7:0] b);
    if (d == 0) rq0.push_back(b);
    else        rq1.push_back(b);
    @(negedge clk);
    in_req[d] = 1'b1;
    wait_done(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      kb_data[d] = 8'h00; kb_valid[d] = 1'b0; in_req[d] = 1'b0; in_flush[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_stall", 32'(in_stall[d]), 0);
      check("rst_done", 32'(in_done[d]), 0);
      check("rst_data", in_data[d], 0);
      check("rst_echo", 32'(echo_valid[d]), 0);
      check("rst_count", 32'(count[d]), 0);
      check("rst_ovf", 32'(overflow[d]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Immediate commit, single-cycle stall
    send(0, 8'h41, 1);
    check("t1_count1", 32'(count[0]), 1);
    rq0.push_back(8'h41);
    in_req[0] = 1'b1;
    #1 check("t1_stall_hi", 32'(in_stall[0]), 1);
    @(negedge clk);
    check("t1_done", 32'(in_done[0]), 1);
    check("t1_stall_lo", 32'(in_stall[0]), 0);
    check("t1_count0", 32'(count[0]), 0);
    in_req[0] = 1'b0;
    @(negedge clk);
    check("t1_done_once", 32'(in_done[0]), 0);

    // Line editing: stall until Enter
    rq1.push_back(8'h48);
    in_req[1] = 1'b1;
    send(1, 8'h48, 1);
    send(1, 8'h49, 1);
    send(1, 8'h08, 1);
    send(1, 8'h4F, 1);
    check("t2_stall_pre", 32'(in_stall[1]), 1);
    check("t2_count_pre", 32'(count[1]), 0);
    send(1, 8'h0D, 1);
    check("t2_count_cr", 32'(count[1]), 3);
    wait_done(1);
    do_read(1, 8'h4F);
    do_read(1, 8'h0D);
    @(negedge clk);
    check("t2_count_end", 32'(count[1]), 0);

    // Overflow with immediate commit
    for (int i = 0; i < 16; i++) send(0, 8'(8'h30 + i), 1);
    send(0, 8'h40, 0);
    check("t3_ovf", 32'(overflow[0]), 1);
    check("t3_count", 32'(count[0]), 16);
    for (int i = 0; i < 16; i++) do_read(0, 8'(8'h30 + i));
    @(negedge clk);
    check("t3_count_end", 32'(count[0]), 0);
    check("t3_ovf_sticky", 32'(overflow[0]), 1);

    // Forced commit of a full uncommitted line
    for (int i = 0; i < 15; i++) send(1, 8'(8'h61 + i), 1);
    check("t4_count15", 32'(count[1]), 0);
    send(1, 8'h70, 1);
    check("t4_count16", 32'(count[1]), 16);
    check("t4_ovf_pre", 32'(overflow[1]), 0);
    send(1, 8'h71, 0);
    check("t4_ovf", 32'(overflow[1]), 1);
    do_read(1, 8'h61);
    send(1, 8'h08, 0);
    @(negedge clk);
    check("t4_bksp_count", 32'(count[1]), 15);

    // Flush beats a simultaneous keystroke
    kb_data[1] = 8'h41; kb_valid[1] = 1'b1; in_flush[1] = 1'b1;
    @(negedge clk);
    kb_valid[1] = 1'b0; in_flush[1] = 1'b0;
    check("t5_count", 32'(count[1]), 0);
    check("t5_ovf", 32'(overflow[1]), 0);
    send(1, 8'h08, 0);
    send(1, 8'h0D, 1);
    check("t5_count_cr", 32'(count[1]), 1);
    do_read(1, 8'h0D);

    // Reset while waiting
    @(negedge clk);
    in_req[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_wait_stall", 32'(in_stall[1]), 1);
    rst = 1'b1;
    #1;
    check("t6_rst_stall", 32'(in_stall[1]), 0);
    check("t6_rst_done", 32'(in_done[1]), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("t6_rel_stall", 32'(in_stall[1]), 1);
    repeat (2) @(negedge clk);
    check("t6_wait_again", 32'(in_stall[1]), 1);
    check("t6_no_done", 32'(in_done[1]), 0);
    in_req[1] = 1'b0;
    repeat (2) @(negedge clk);

    check("left_eq0", eq0.size(), 0);
    check("left_eq1", eq1.size(), 0);
    check("left_rq0", rq0.size(), 0);
    check("left_rq1", rq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
